transport_fsm: RTL and testbench
================================

TRANSPORT_FSM -- requirements
Module: transport_fsm

Interface
REQ-001 Parameter NUM_TRACKS, default 4: number of independently record-armable tracks, range 1..16.
REQ-002 Parameter SONG_W, default 4: song-name and song-choice width.
REQ-003 Parameter EFX_W, default 7: effect-enable vector width.
REQ-004 Parameter EFXVAL_W, default 17: packed effect-value vector width.
REQ-005 Parameter REMAP_THRESH, default 6; parameter REMAP_OFFSET, default 2: song-address remap constants.
REQ-006 clk  in  1  system clock, all logic on posedge.
REQ-007 reset_n  in  1  synchronous, active-low reset.
REQ-008 but_ent  in  1  start/stop button, synced/debounced level.
REQ-009 but_pause  in  1  pause button, synced/debounced level.
REQ-010 song_name_sel  in  SONG_W  requested song.
REQ-011 track_arm_sel  in  NUM_TRACKS  per-track record-arm request.
REQ-012 effects_sel  in  EFX_W  requested effect enables.
REQ-013 effect_values_sel  in  EFXVAL_W  requested effect values.
REQ-014 song_done  in  1  end-of-song from memory, level.
REQ-015 song_name  out  SONG_W  latched song name, to graphics.
REQ-016 song_choice  out  SONG_W  remapped memory song index.
REQ-017 track_rec_en  out  NUM_TRACKS  latched per-track record enables.
REQ-018 effects, effect_values  out  EFX_W, EFXVAL_W  latched effect settings.
REQ-019 start_song  out  1  one-cycle start strobe to memory.
REQ-020 pause_song  out  1  1 = memory incrementing halted.
REQ-021 cfsm_state  out  2  current state encoding.

Function
REQ-022 States SHALL be STANDBY=00, PLAY=01, RECORD=10, PAUSED=11.
REQ-023 Button events SHALL be rising edges only (prev=0, cur=1), prev registers updated every cycle.
REQ-024 STANDBY + but_ent edge SHALL latch all *_sel inputs and go to RECORD if any track_arm_sel bit is 1, else PLAY.
REQ-025 song_choice SHALL equal song_name_sel if below REMAP_THRESH, else song_name_sel+REMAP_OFFSET truncated to SONG_W.
REQ-026 start_song SHALL pulse high exactly one cycle, the cycle after the state enters PLAY/RECORD from STANDBY.
REQ-027 pause_song SHALL be 0 in PLAY/RECORD and 1 in STANDBY/PAUSED, registered with the state.
REQ-028 PLAY/RECORD + but_pause edge SHALL go to PAUSED, storing resume target; PAUSED + but_pause edge SHALL return to that target without start_song.
REQ-029 PLAY/RECORD/PAUSED + but_ent edge SHALL go to STANDBY.
REQ-030 song_done in PLAY/RECORD/PAUSED SHALL go to STANDBY, except as REQ-037.
REQ-031 song_done, but_ent and but_pause events during the start_song cycle SHALL be ignored.
REQ-032 Simultaneous events priority: song_done > but_ent > but_pause.
REQ-033 Latched outputs SHALL change only on STANDBY->PLAY/RECORD transition and reset.
REQ-034 track_rec_en SHALL read all-zero outside RECORD and PAUSED-from-RECORD.

Reset
REQ-035 reset_n=0 at a clock edge SHALL force STANDBY, pause_song=1, start_song=0, track_rec_en=0, effects=0, effect_values=0, song_name=0, song_choice=0, mid-operation included.
REQ-036 Button prev registers SHALL reset to 1 so a button held through reset produces no event.

Configuration
REQ-037 With LOOP_PLAYBACK_EN defined, song_done in PLAY SHALL re-issue start_song one cycle later and stay in PLAY; without it, REQ-030 applies unconditionally. RECORD always stops on song_done.

Structure
REQ-038 State encoding localparams and remap constants SHALL live in package transport_pkg.
REQ-039 Edge detection SHALL be sub-module edge_detect (one instance per button, reset-high prev).

Verification
REQ-040 Reset, song_name_sel=7, arm=0000, but_ent edge -> PLAY, song_choice=9, single start_song pulse, pause_song=0.
REQ-041 arm=0101, song_name_sel=3, but_ent edge -> RECORD, track_rec_en=0101, song_choice=3.
REQ-042 In PLAY, but_pause edge -> PAUSED, pause_song=1; second edge -> PLAY, no start_song.
REQ-043 song_done and but_ent edge same cycle in RECORD -> STANDBY, pause_song=1, track_rec_en=0.
REQ-044 but_ent held high through reset release -> remains STANDBY, no start_song.
REQ-045 LOOP_PLAYBACK_EN defined, song_done in PLAY -> stays 01, start_song pulses one cycle; undefined -> STANDBY.

Source files
------------

// File: rtl/transport_pkg.sv
// Shared state encodings and song-address remap defaults for the transport controller.
package transport_pkg;

    localparam logic [1:0] STATE_STANDBY = 2'b00;
    localparam logic [1:0] STATE_PLAY    = 2'b01;
    localparam logic [1:0] STATE_RECORD  = 2'b10;
    localparam logic [1:0] STATE_PAUSED  = 2'b11;

    typedef enum logic [1:0] {
        ST_STANDBY = STATE_STANDBY,
        ST_PLAY    = STATE_PLAY,
        ST_RECORD  = STATE_RECORD,
        ST_PAUSED  = STATE_PAUSED
    } state_t;

    localparam int DEF_REMAP_THRESH = 6;
    localparam int DEF_REMAP_OFFSET = 2;

endpackage

// File: rtl/edge_detect.sv
// Rising-edge detector for a synced button level; prev resets high so a button
// held through reset does not look like a fresh press.
module edge_detect (
    input  logic clk,
    input  logic reset_n,
    input  logic i_level,
    output logic o_rise
);

    logic r_prev;

    // NOTE: sequential state is always assigned with <= so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_prev <= 1'b1;
        end else begin
            r_prev <= i_level;
        end
    end

    assign o_rise = i_level & ~r_prev;

endmodule

// File: rtl/transport_fsm.sv
// Transport controller: standby/play/record/pause sequencing with latched song settings.
// Optional build macro LOOP_PLAYBACK_EN restarts the song on song_done while in PLAY.
module transport_fsm
    import transport_pkg::*;
#(
    parameter int NUM_TRACKS   = 4,
    parameter int SONG_W       = 4,
    parameter int EFX_W        = 7,
    parameter int EFXVAL_W     = 17,
    parameter int REMAP_THRESH = DEF_REMAP_THRESH,
    parameter int REMAP_OFFSET = DEF_REMAP_OFFSET
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  but_ent,
    input  logic                  but_pause,
    input  logic [SONG_W-1:0]     song_name_sel,
    input  logic [NUM_TRACKS-1:0] track_arm_sel,
    input  logic [EFX_W-1:0]      effects_sel,
    input  logic [EFXVAL_W-1:0]   effect_values_sel,
    input  logic                  song_done,
    output logic [SONG_W-1:0]     song_name,
    output logic [SONG_W-1:0]     song_choice,
    output logic [NUM_TRACKS-1:0] track_rec_en,
    output logic [EFX_W-1:0]      effects,
    output logic [EFXVAL_W-1:0]   effect_values,
    output logic                  start_song,
    output logic                  pause_song,
    output logic [1:0]            cfsm_state
);

    state_t                r_state, w_next_state;
    state_t                r_resume, w_next_resume;
    logic                  r_start_song, w_start_next;
    logic                  r_pause_song;
    logic                  w_latch;
    logic                  w_ent_ev, w_pause_ev;
    logic [SONG_W-1:0]     w_choice;
    logic [SONG_W-1:0]     r_song_name, r_song_choice;
    logic [NUM_TRACKS-1:0] r_track_rec;
    logic [EFX_W-1:0]      r_effects;
    logic [EFXVAL_W-1:0]   r_effect_values;

    edge_detect u_ent_edge (
        .clk     (clk),
        .reset_n (reset_n),
        .i_level (but_ent),
        .o_rise  (w_ent_ev)
    );

    edge_detect u_pause_edge (
        .clk     (clk),
        .reset_n (reset_n),
        .i_level (but_pause),
        .o_rise  (w_pause_ev)
    );

    assign w_choice = (int'(song_name_sel) < REMAP_THRESH) ? song_name_sel
                                                           : song_name_sel + SONG_W'(REMAP_OFFSET);

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        w_next_state  = r_state;
        w_next_resume = r_resume;
        w_start_next  = 1'b0;
        w_latch       = 1'b0;
        case (r_state)
            ST_STANDBY: begin
                if (w_ent_ev) begin
                    w_latch      = 1'b1;
                    w_start_next = 1'b1;
                    w_next_state = (|track_arm_sel) ? ST_RECORD : ST_PLAY;
                end
            end
            ST_PLAY, ST_RECORD: begin
                // The start_song cycle belongs to the memory handshake; events there are dropped.
                if (!r_start_song) begin
                    if (song_done) begin
`ifdef LOOP_PLAYBACK_EN
                        if (r_state == ST_PLAY) begin
                            w_start_next = 1'b1;
                        end else begin
                            w_next_state = ST_STANDBY;
                        end
`else
                        w_next_state = ST_STANDBY;
`endif
                    end else if (w_ent_ev) begin
                        w_next_state = ST_STANDBY;
                    end else if (w_pause_ev) begin
                        w_next_resume = r_state;
                        w_next_state  = ST_PAUSED;
                    end
                end
            end
            ST_PAUSED: begin
                if (song_done || w_ent_ev) begin
                    w_next_state = ST_STANDBY;
                end else if (w_pause_ev) begin
                    w_next_state = r_resume;
                end
            end
            default: w_next_state = ST_STANDBY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state         <= ST_STANDBY;
            r_resume        <= ST_PLAY;
            r_start_song    <= 1'b0;
            r_pause_song    <= 1'b1;
            r_song_name     <= '0;
            r_song_choice   <= '0;
            r_track_rec     <= '0;
            r_effects       <= '0;
            r_effect_values <= '0;
        end else begin
            r_state      <= w_next_state;
            r_resume     <= w_next_resume;
            r_start_song <= w_start_next;
            r_pause_song <= (w_next_state == ST_STANDBY) || (w_next_state == ST_PAUSED);
            if (w_latch) begin
                r_song_name     <= song_name_sel;
                r_song_choice   <= w_choice;
                r_track_rec     <= track_arm_sel;
                r_effects       <= effects_sel;
                r_effect_values <= effect_values_sel;
            end
        end
    end

    // Armed tracks stay latched but only reach the recorder while a recording is live or paused.
    assign track_rec_en  = ((r_state == ST_RECORD) ||
                            (r_state == ST_PAUSED && r_resume == ST_RECORD)) ? r_track_rec : '0;
    assign song_name     = r_song_name;
    assign song_choice   = r_song_choice;
    assign effects       = r_effects;
    assign effect_values = r_effect_values;
    assign start_song    = r_start_song;
    assign pause_song    = r_pause_song;
    assign cfsm_state    = r_state;

endmodule

// File: tb/tb_transport_fsm.sv
// Self-checking bench for transport_fsm: a per-cycle vector table plus hand-written
// sequences for latching, priority, remap boundaries and reset corner cases.
module tb_transport_fsm;

`ifdef LOOP_PLAYBACK_EN
    localparam bit LOOP = 1'b1;
`else
    localparam bit LOOP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        but_ent = 1'b0;
    logic        but_pause = 1'b0;
    logic [3:0]  song_name_sel = '0;
    logic [3:0]  track_arm_sel = '0;
    logic [6:0]  effects_sel = '0;
    logic [16:0] effect_values_sel = '0;
    logic        song_done = 1'b0;
    logic [3:0]  song_name, song_choice, track_rec_en;
    logic [6:0]  effects;
    logic [16:0] effect_values;
    logic        start_song, pause_song;
    logic [1:0]  cfsm_state;

    int total = 0;
    int bad   = 0;

    transport_fsm dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .but_ent           (but_ent),
        .but_pause         (but_pause),
        .song_name_sel     (song_name_sel),
        .track_arm_sel     (track_arm_sel),
        .effects_sel       (effects_sel),
        .effect_values_sel (effect_values_sel),
        .song_done         (song_done),
        .song_name         (song_name),
        .song_choice       (song_choice),
        .track_rec_en      (track_rec_en),
        .effects           (effects),
        .effect_values     (effect_values),
        .start_song        (start_song),
        .pause_song        (pause_song),
        .cfsm_state        (cfsm_state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst_n, ent, pau, done;
        logic [3:0] name, arm;
        logic [1:0] st;
        logic       start, paus;
        logic [3:0] rec, choice;
    } vec_t;

    vec_t vecs[24];

    function automatic vec_t mk(input logic r, input logic e, input logic p, input logic d,
                                input logic [3:0] nm, input logic [3:0] ar,
                                input logic [1:0] st, input logic s, input logic ps,
                                input logic [3:0] rc, input logic [3:0] ch);
        vec_t v;
        v.rst_n = r; v.ent = e; v.pau = p; v.done = d;
        v.name = nm; v.arm = ar;
        v.st = st; v.start = s; v.paus = ps; v.rec = rc; v.choice = ch;
        return v;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        step();
        step();
        reset_n = 1'b1;
        step();
    endtask

    initial begin
        //            rst ent pau done name arm   st  start paus rec  choice
        vecs[0]  = mk(0, 0, 0, 0, 4'd7, 4'h0, 2'd0, 0, 1, 4'h0, 4'd0);
        vecs[1]  = mk(1, 0, 0, 0, 4'd7, 4'h0, 2'd0, 0, 1, 4'h0, 4'd0);
        vecs[2]  = mk(1, 1, 0, 0, 4'd7, 4'h0, 2'd1, 1, 0, 4'h0, 4'd9);
        vecs[3]  = mk(1, 1, 0, 0, 4'd7, 4'h0, 2'd1, 0, 0, 4'h0, 4'd9);
        vecs[4]  = mk(1, 0, 0, 0, 4'd7, 4'h0, 2'd1, 0, 0, 4'h0, 4'd9);
        vecs[5]  = mk(1, 0, 1, 0, 4'd7, 4'h0, 2'd3, 0, 1, 4'h0, 4'd9);
        vecs[6]  = mk(1, 0, 0, 0, 4'd7, 4'h0, 2'd3, 0, 1, 4'h0, 4'd9);
        vecs[7]  = mk(1, 0, 1, 0, 4'd7, 4'h0, 2'd1, 0, 0, 4'h0, 4'd9);
        vecs[8]  = mk(1, 0, 0, 0, 4'd7, 4'h0, 2'd1, 0, 0, 4'h0, 4'd9);
        vecs[9]  = mk(1, 1, 0, 0, 4'd7, 4'h0, 2'd0, 0, 1, 4'h0, 4'd9);
        vecs[10] = mk(1, 0, 0, 0, 4'd3, 4'h5, 2'd0, 0, 1, 4'h0, 4'd9);
        vecs[11] = mk(1, 1, 0, 0, 4'd3, 4'h5, 2'd2, 1, 0, 4'h5, 4'd3);
        vecs[12] = mk(1, 0, 0, 1, 4'd3, 4'h5, 2'd2, 0, 0, 4'h5, 4'd3);
        vecs[13] = mk(1, 0, 0, 0, 4'd3, 4'h5, 2'd2, 0, 0, 4'h5, 4'd3);
        vecs[14] = mk(1, 0, 1, 0, 4'd3, 4'h5, 2'd3, 0, 1, 4'h5, 4'd3);
        vecs[15] = mk(1, 0, 0, 0, 4'd3, 4'h5, 2'd3, 0, 1, 4'h5, 4'd3);
        vecs[16] = mk(1, 0, 1, 0, 4'd3, 4'h5, 2'd2, 0, 0, 4'h5, 4'd3);
        vecs[17] = mk(1, 0, 0, 0, 4'd3, 4'h5, 2'd2, 0, 0, 4'h5, 4'd3);
        vecs[18] = mk(1, 1, 0, 1, 4'd3, 4'h5, 2'd0, 0, 1, 4'h0, 4'd3);
        vecs[19] = mk(1, 0, 0, 0, 4'd7, 4'h0, 2'd0, 0, 1, 4'h0, 4'd3);
        vecs[20] = mk(1, 1, 0, 0, 4'd7, 4'h0, 2'd1, 1, 0, 4'h0, 4'd9);
        vecs[21] = mk(1, 0, 0, 0, 4'd7, 4'h0, 2'd1, 0, 0, 4'h0, 4'd9);
        vecs[22] = LOOP ? mk(1, 0, 0, 1, 4'd7, 4'h0, 2'd1, 1, 0, 4'h0, 4'd9)
                        : mk(1, 0, 0, 1, 4'd7, 4'h0, 2'd0, 0, 1, 4'h0, 4'd9);
        vecs[23] = LOOP ? mk(1, 0, 0, 0, 4'd7, 4'h0, 2'd1, 0, 0, 4'h0, 4'd9)
                        : mk(1, 0, 0, 0, 4'd7, 4'h0, 2'd0, 0, 1, 4'h0, 4'd9);

        for (int i = 0; i < 24; i++) begin
            reset_n       = vecs[i].rst_n;
            but_ent       = vecs[i].ent;
            but_pause     = vecs[i].pau;
            song_done     = vecs[i].done;
            song_name_sel = vecs[i].name;
            track_arm_sel = vecs[i].arm;
            step();
            check($sformatf("v%0d.state", i),  cfsm_state,   vecs[i].st);
            check($sformatf("v%0d.start", i),  start_song,   vecs[i].start);
            check($sformatf("v%0d.pause", i),  pause_song,   vecs[i].paus);
            check($sformatf("v%0d.rec", i),    track_rec_en, vecs[i].rec);
            check($sformatf("v%0d.choice", i), song_choice,  vecs[i].choice);
        end
        but_ent = 1'b0; but_pause = 1'b0; song_done = 1'b0;

        // Latching of all settings, stability afterwards, and priority within RECORD.
        do_reset();
        song_name_sel = 4'd4; track_arm_sel = 4'b0010;
        effects_sel = 7'h55; effect_values_sel = 17'h1ABCD;
        but_ent = 1'b1;
        step();
        check("latch.state",  cfsm_state,    2'd2);
        check("latch.name",   song_name,     4'd4);
        check("latch.choice", song_choice,   4'd4);
        check("latch.rec",    track_rec_en,  4'b0010);
        check("latch.efx",    effects,       7'h55);
        check("latch.efxval", effect_values, 17'h1ABCD);
        but_ent = 1'b0;
        song_name_sel = 4'd12; track_arm_sel = 4'b1001;
        effects_sel = 7'h2A; effect_values_sel = 17'h00F0F;
        step(); step(); step();
        check("hold.name",   song_name,     4'd4);
        check("hold.rec",    track_rec_en,  4'b0010);
        check("hold.efx",    effects,       7'h55);
        check("hold.efxval", effect_values, 17'h1ABCD);
        song_done = 1'b1; but_pause = 1'b1;
        step();
        check("done_over_pause.state", cfsm_state, 2'd0);
        check("done_over_pause.rec",   track_rec_en, 4'h0);
        song_done = 1'b0; but_pause = 1'b0;
        step();
        but_ent = 1'b1;
        step();
        check("rearm.state", cfsm_state,   2'd2);
        check("rearm.rec",   track_rec_en, 4'b1001);
        check("rearm.name",  song_name,    4'd12);
        but_ent = 1'b0;
        step();
        but_ent = 1'b1; but_pause = 1'b1;
        step();
        check("ent_over_pause.state", cfsm_state, 2'd0);
        but_ent = 1'b0; but_pause = 1'b0;
        step();
        but_ent = 1'b1;
        step();
        but_ent = 1'b0;
        step();
        reset_n = 1'b0;
        step();
        check("midrst.state",  cfsm_state,    2'd0);
        check("midrst.start",  start_song,    1'b0);
        check("midrst.pause",  pause_song,    1'b1);
        check("midrst.rec",    track_rec_en,  4'h0);
        check("midrst.efx",    effects,       7'h0);
        check("midrst.efxval", effect_values, 17'h0);
        check("midrst.name",   song_name,     4'h0);
        check("midrst.choice", song_choice,   4'h0);
        reset_n = 1'b1;
        effects_sel = '0; effect_values_sel = '0; track_arm_sel = '0;

        // Remap boundaries: just below threshold, at threshold, wrap at the top, zero.
        begin
            logic [3:0] names [4];
            logic [3:0] exps  [4];
            names = '{4'd5, 4'd6, 4'd15, 4'd0};
            exps  = '{4'd5, 4'd8, 4'd1,  4'd0};
            for (int k = 0; k < 4; k++) begin
                do_reset();
                song_name_sel = names[k];
                but_ent = 1'b1;
                step();
                check($sformatf("remap%0d.choice", k), song_choice, exps[k]);
                check($sformatf("remap%0d.name", k),   song_name,   names[k]);
                but_ent = 1'b0;
            end
        end

        // A button held through reset release must not start a song.
        but_ent = 1'b1;
        reset_n = 1'b0;
        step(); step();
        reset_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            check($sformatf("held%0d.state", k), cfsm_state, 2'd0);
            check($sformatf("held%0d.start", k), start_song, 1'b0);
        end
        but_ent = 1'b0;
        step();
        but_ent = 1'b1;
        step();
        check("held_release.state", cfsm_state, 2'd1);
        check("held_release.start", start_song, 1'b1);
        but_ent = 1'b0;
        step();
        check("held_release.start_off", start_song, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
